// File: rtl/player_shot_ctl.sv
// Single-slot player missile controller: launch on fire edge, climb on the
// movement tick, retire on hit or at the top edge, then wait out a cooldown.
module player_shot_ctl #(
    parameter int unsigned PLAYER_WIDTH   = 32,
    parameter int unsigned SHOT_WIDTH     = 2,
    parameter int unsigned SHOT_HEIGHT    = 8,
    parameter int unsigned PLAYER_Y       = 700,
    parameter int unsigned SHOT_SPEED     = 4,
    parameter int unsigned TICK_DELAY     = 250000,
    parameter int unsigned COOLDOWN_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_fire,
    input  logic [11:0] player_xpos,
    input  logic        hit,
    output logic        shot_active,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos,
    output logic        shot_fired
);

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        COOLDOWN
    } state_t;

    localparam logic [11:0] X_OFFSET = 12'(PLAYER_WIDTH / 2) - 12'(SHOT_WIDTH / 2);
    localparam logic [11:0] LAUNCH_Y = 12'(PLAYER_Y - SHOT_HEIGHT);
    localparam logic [11:0] SPEED    = 12'(SHOT_SPEED);

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] cd_cnt_q, cd_cnt_d;
    logic        button_q;
    logic        active_q, active_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        fired_q, fired_d;
    logic        tick;
    logic        fire_req;

    always_comb begin
        tick       = (tick_cnt_q == TICK_DELAY);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
    end

    assign fire_req = button_fire & ~button_q;

    always_comb begin
        state_d  = state_q;
        cd_cnt_d = cd_cnt_q;
        active_d = active_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        fired_d  = 1'b0;

        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (fire_req) begin
                    state_d  = FLY;
                    active_d = 1'b1;
                    fired_d  = 1'b1;
                    xpos_d   = player_xpos + X_OFFSET;
                    ypos_d   = LAUNCH_Y;
                end
            end
            FLY: begin
                // A hit wins over a tick landing in the same cycle.
                if (hit || (tick && ypos_q <= SPEED)) begin
                    state_d  = COOLDOWN;
                    active_d = 1'b0;
                    cd_cnt_d = '0;
                end else if (tick) begin
                    ypos_d = ypos_q - SPEED;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_q >= COOLDOWN_TICKS) begin
                    state_d = IDLE;
                end else if (tick) begin
                    cd_cnt_d = cd_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            cd_cnt_q   <= '0;
            // Held high so a button pressed across reset does not launch.
            button_q   <= 1'b1;
            active_q   <= 1'b0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            fired_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            button_q   <= button_fire;
            active_q   <= active_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            fired_q    <= fired_d;
        end
    end

    assign shot_active = active_q;
    assign shot_xpos   = xpos_q;
    assign shot_ypos   = ypos_q;
    assign shot_fired  = fired_q;

endmodule

// File: tb/tb_player_shot_ctl.sv
// Directed bench for player_shot_ctl with a short tick (every 4 cycles) and a
// 2-tick cooldown.
module tb_player_shot_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button_fire = 1'b0;
    logic [11:0] player_xpos = '0;
    logic        hit = 1'b0;
    logic        shot_active;
    logic [11:0] shot_xpos;
    logic [11:0] shot_ypos;
    logic        shot_fired;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    player_shot_ctl #(
        .PLAYER_WIDTH  (32),
        .SHOT_WIDTH    (2),
        .SHOT_HEIGHT   (8),
        .PLAYER_Y      (100),
        .SHOT_SPEED    (4),
        .TICK_DELAY    (3),
        .COOLDOWN_TICKS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_fire(button_fire),
        .player_xpos(player_xpos),
        .hit        (hit),
        .shot_active(shot_active),
        .shot_xpos  (shot_xpos),
        .shot_ypos  (shot_ypos),
        .shot_fired (shot_fired)
    );

    always #5 clk = ~clk;

    // Phase of the movement tick: a tick is seen during the cycle where cyc==3.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= (cyc == 3) ? 0 : cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        button_fire = 1'b0;
        hit = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press();
        button_fire = 1'b0;
        step();
        button_fire = 1'b1;
        step();
        button_fire = 1'b0;
    endtask

    // Steps through the next tick edge; n returns the cycles advanced.
    task automatic wait_tick(output int n);
        n = 0;
        while (cyc != 3 && n < 8) begin
            step();
            n++;
        end
        step();
        n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button_fire = 1'b1;
        hit = 1'b0;
        repeat (3) step();
        checks++;
        if (shot_active !== 1'b0 || shot_xpos !== 12'd0 || shot_ypos !== 12'd0 || shot_fired !== 1'b0)
            begin errors++; $display("FAIL reset_values: active=%b x=%0d y=%0d fired=%b required 0/0/0/0", shot_active, shot_xpos, shot_ypos, shot_fired); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (shot_active !== 1'b0 || shot_fired !== 1'b0)
                begin errors++; $display("FAIL held_button_no_fire: cycle %0d active=%b fired=%b required 0/0", i, shot_active, shot_fired); end
        end
        button_fire = 1'b0;
        hit = 1'b1;
        repeat (3) step();
        hit = 1'b0;
        checks++;
        if (shot_active !== 1'b0)
            begin errors++; $display("FAIL idle_hit: active=%b required 0", shot_active); end
        player_xpos = 12'd100;
        press();
        checks++;
        if (shot_active !== 1'b1 || shot_fired !== 1'b1)
            begin errors++; $display("FAIL release_then_press: active=%b fired=%b required 1/1", shot_active, shot_fired); end
    endtask

    task automatic test_flight();
        int n;
        logic [11:0] exp_y;
        do_reset();
        player_xpos = 12'd100;
        press();
        checks++;
        if (shot_active !== 1'b1 || shot_xpos !== 12'd115 || shot_ypos !== 12'd92 || shot_fired !== 1'b1)
            begin errors++; $display("FAIL launch: active=%b x=%0d y=%0d fired=%b required 1/115/92/1", shot_active, shot_xpos, shot_ypos, shot_fired); end
        step();
        checks++;
        if (shot_fired !== 1'b0)
            begin errors++; $display("FAIL fired_pulse_width: fired=%b required 0", shot_fired); end
        for (int k = 1; k <= 22; k++) begin
            wait_tick(n);
            exp_y = 12'(92 - 4 * k);
            checks++;
            if (shot_ypos !== exp_y || shot_active !== 1'b1)
                begin errors++; $display("FAIL flight_step: tick %0d y=%0d active=%b required %0d/1", k, shot_ypos, shot_active, exp_y); end
            if (k > 1) begin
                checks++;
                if (n != 4)
                    begin errors++; $display("FAIL tick_period: tick %0d cycles=%0d required 4", k, n); end
            end
        end
        wait_tick(n);
        checks++;
        if (shot_active !== 1'b0 || shot_ypos !== 12'd4 || shot_xpos !== 12'd115)
            begin errors++; $display("FAIL off_top: active=%b x=%0d y=%0d required 0/115/4", shot_active, shot_xpos, shot_ypos); end
    endtask

    task automatic test_ignored_fire();
        int n;
        do_reset();
        player_xpos = 12'd100;
        press();
        step();
        press();
        checks++;
        if (shot_fired !== 1'b0 || shot_active !== 1'b1)
            begin errors++; $display("FAIL fire_in_fly: fired=%b active=%b required 0/1", shot_fired, shot_active); end
        while (cyc != 0) step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        checks++;
        if (shot_active !== 1'b0)
            begin errors++; $display("FAIL hit_retire: active=%b required 0", shot_active); end
        press();
        checks++;
        if (shot_fired !== 1'b0 || shot_active !== 1'b0)
            begin errors++; $display("FAIL fire_in_cooldown0: fired=%b active=%b required 0/0", shot_fired, shot_active); end
        wait_tick(n);
        press();
        checks++;
        if (shot_fired !== 1'b0 || shot_active !== 1'b0)
            begin errors++; $display("FAIL fire_in_cooldown1: fired=%b active=%b required 0/0", shot_fired, shot_active); end
        wait_tick(n);
        press();
        checks++;
        if (shot_fired !== 1'b1 || shot_active !== 1'b1)
            begin errors++; $display("FAIL fire_after_cooldown: fired=%b active=%b required 1/1", shot_fired, shot_active); end
    endtask

    task automatic test_hit_on_tick();
        int n;
        do_reset();
        player_xpos = 12'd100;
        press();
        for (int k = 0; k < 8; k++) wait_tick(n);
        checks++;
        if (shot_ypos !== 12'd60)
            begin errors++; $display("FAIL reach_60: y=%0d required 60", shot_ypos); end
        while (cyc != 3) step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        checks++;
        if (shot_active !== 1'b0 || shot_ypos !== 12'd60)
            begin errors++; $display("FAIL hit_priority: active=%b y=%0d required 0/60", shot_active, shot_ypos); end
        wait_tick(n);
        checks++;
        if (shot_active !== 1'b0 || shot_ypos !== 12'd60)
            begin errors++; $display("FAIL hold_after_hit: active=%b y=%0d required 0/60", shot_active, shot_ypos); end
        press();
        checks++;
        if (shot_fired !== 1'b0)
            begin errors++; $display("FAIL cooldown_after_hit: fired=%b required 0", shot_fired); end
    endtask

    task automatic test_x_frozen();
        int n;
        do_reset();
        player_xpos = 12'd100;
        press();
        player_xpos = 12'd300;
        for (int k = 0; k < 3; k++) wait_tick(n);
        checks++;
        if (shot_xpos !== 12'd115 || shot_ypos !== 12'd80)
            begin errors++; $display("FAIL x_frozen: x=%0d y=%0d required 115/80", shot_xpos, shot_ypos); end
        hit = 1'b1;
        step();
        hit = 1'b0;
        wait_tick(n);
        wait_tick(n);
        step();
        press();
        checks++;
        if (shot_fired !== 1'b1 || shot_xpos !== 12'd315 || shot_ypos !== 12'd92)
            begin errors++; $display("FAIL relaunch_x: fired=%b x=%0d y=%0d required 1/315/92", shot_fired, shot_xpos, shot_ypos); end
    endtask

    task automatic test_reset_mid_flight();
        int n;
        do_reset();
        player_xpos = 12'd100;
        press();
        wait_tick(n);
        wait_tick(n);
        checks++;
        if (shot_ypos !== 12'd84 || shot_active !== 1'b1)
            begin errors++; $display("FAIL pre_reset_flight: y=%0d active=%b required 84/1", shot_ypos, shot_active); end
        rst = 1'b1;
        step();
        checks++;
        if (shot_active !== 1'b0 || shot_xpos !== 12'd0 || shot_ypos !== 12'd0 || shot_fired !== 1'b0)
            begin errors++; $display("FAIL reset_mid_flight: active=%b x=%0d y=%0d fired=%b required 0/0/0/0", shot_active, shot_xpos, shot_ypos, shot_fired); end
        rst = 1'b0;
        press();
        checks++;
        if (shot_fired !== 1'b1 || shot_xpos !== 12'd115 || shot_ypos !== 12'd92)
            begin errors++; $display("FAIL launch_after_reset: fired=%b x=%0d y=%0d required 1/115/92", shot_fired, shot_xpos, shot_ypos); end
    endtask

    initial begin
        test_reset();
        test_flight();
        test_ignored_fire();
        test_hit_on_tick();
        test_x_frozen();
        test_reset_mid_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
